// File: rtl/uvma_tcounter_b_pkg.sv
// Shared definitions for the tcounter_b timer: register map, CTRL bit
// positions and the architectural layout of the CTRL register.
package uvma_tcounter_b_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CMP    = 2'd1;
    localparam logic [1:0] ADDR_CNT    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_ONE_SHOT_BIT = 1;
    localparam int CTRL_CLR_BIT      = 2;
    localparam int CTRL_PRESC_LSB    = 8;

    localparam int STATUS_IRQ_BIT = 0;
    localparam int STATUS_OVF_BIT = 1;

    // Full 32-bit view of a CTRL write; the prescaler field is sized for the
    // widest legal PRESC_W and narrowed by the timer.
    typedef struct packed {
        logic [23:0] presc;
        logic [4:0]  rsvd;
        logic        clr;
        logic        one_shot;
        logic        en;
    } ctrl_t;

endpackage

// File: rtl/uvma_tcounter_b_if.sv
// Register bus and event outputs of the tcounter_b timer.
// Handshake: wr_en/rd_en are single-cycle strobes with no back-pressure; a
// write is taken on every cycle wr_en is high, and rdata carries the value
// addressed by rd_en on the following cycle, holding it until the next read.
interface uvma_tcounter_b_if;
    import uvma_tcounter_b_pkg::*;

    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        evt;
    logic        ovf;
    logic        irq;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, evt, ovf, irq
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, evt, ovf, irq
    );

endinterface

// File: rtl/uvma_tcounter_b_presc.sv
// Prescaler: counts 0..presc while enabled and emits a tick on the last count.
module uvma_tcounter_b_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);
    import uvma_tcounter_b_pkg::*;

    logic [PRESC_W-1:0] pcnt_q;
    logic [PRESC_W-1:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == presc_i);

    // Next prescaler count: clear wins, wrap on tick, hold while disabled.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (tick_o) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = pcnt_q + PRESC_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/uvma_tcounter_b_timer.sv
// Timer/counter responder: register file, prescaled counter with compare and
// wrap events, sticky status with write-1-to-clear, registered read port.
module uvma_tcounter_b_timer #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    uvma_tcounter_b_if.slave   bus
);
    import uvma_tcounter_b_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               en_q, en_d;
    logic               one_shot_q, one_shot_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cmp_q, cmp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               ovf_seen_q, ovf_seen_d;
    logic               evt_q, evt_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        rd_word;

    ctrl_t ctrl_w;
    logic  wr_ctrl, wr_cmp, wr_cnt, wr_status;
    logic  clr, tick, hit, wrap, cnt_load;
    logic  unused_wdata;

    assign ctrl_w    = ctrl_t'(bus.wdata);
    assign wr_ctrl   = bus.wr_en && (bus.addr == ADDR_CTRL);
    assign wr_cmp    = bus.wr_en && (bus.addr == ADDR_CMP);
    assign wr_cnt    = bus.wr_en && (bus.addr == ADDR_CNT);
    assign wr_status = bus.wr_en && (bus.addr == ADDR_STATUS);
    assign clr       = wr_ctrl && ctrl_w.clr;

    // Reserved and out-of-range write bits are intentionally ignored.
    assign unused_wdata = ^{bus.wdata, ctrl_w};

    uvma_tcounter_b_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en_q),
        .clr_i   (clr),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    // A counter load (CNT write or clr) overrides the tick and drops its events.
    assign hit      = tick && (cnt_q == cmp_q);
    assign wrap     = tick && !hit && (cnt_q == CNT_MAX);
    assign cnt_load = wr_cnt || clr;
    assign evt_d    = hit && !cnt_load;
    assign ovf_d    = wrap && !cnt_load;

    // Next state of registers: hardware update first, then bus writes on top
    // (except status, where a hardware set beats a W1C).
    always_comb begin
        en_d       = en_q;
        one_shot_d = one_shot_q;
        presc_d    = presc_q;
        cmp_d      = cmp_q;
        cnt_d      = cnt_q;
        irq_d      = irq_q;
        ovf_seen_d = ovf_seen_q;

        if (tick) begin
            if (hit || wrap) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (clr) begin
            cnt_d = '0;
        end
        if (wr_cnt) begin
            cnt_d = bus.wdata[CNT_W-1:0];
        end

        if (evt_d && one_shot_q) begin
            en_d = 1'b0;
        end
        if (wr_ctrl) begin
            en_d       = ctrl_w.en;
            one_shot_d = ctrl_w.one_shot;
            presc_d    = ctrl_w.presc[PRESC_W-1:0];
        end
        if (wr_cmp) begin
            cmp_d = bus.wdata[CNT_W-1:0];
        end

        if (wr_status && bus.wdata[STATUS_IRQ_BIT]) begin
            irq_d = 1'b0;
        end
        if (wr_status && bus.wdata[STATUS_OVF_BIT]) begin
            ovf_seen_d = 1'b0;
        end
        if (evt_d) begin
            irq_d = 1'b1;
        end
        if (ovf_d) begin
            ovf_seen_d = 1'b1;
        end
    end

    // Read mux on pre-write values; rdata holds between reads.
    always_comb begin
        rd_word = '0;
        case (bus.addr)
            ADDR_CTRL: begin
                rd_word[CTRL_EN_BIT]                    = en_q;
                rd_word[CTRL_ONE_SHOT_BIT]              = one_shot_q;
                rd_word[CTRL_CLR_BIT]                   = 1'b0;
                rd_word[CTRL_PRESC_LSB +: PRESC_W]      = presc_q;
            end
            ADDR_CMP:    rd_word[CNT_W-1:0] = cmp_q;
            ADDR_CNT:    rd_word[CNT_W-1:0] = cnt_q;
            ADDR_STATUS: begin
                rd_word[STATUS_IRQ_BIT] = irq_q;
                rd_word[STATUS_OVF_BIT] = ovf_seen_q;
            end
            default:     rd_word = '0;
        endcase
        rdata_d = bus.rd_en ? rd_word : rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            one_shot_q <= 1'b0;
            presc_q    <= '0;
            cmp_q      <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            ovf_seen_q <= 1'b0;
            evt_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            en_q       <= en_d;
            one_shot_q <= one_shot_d;
            presc_q    <= presc_d;
            cmp_q      <= cmp_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
            ovf_seen_q <= ovf_seen_d;
            evt_q      <= evt_d;
            ovf_q      <= ovf_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.evt   = evt_q;
    assign bus.ovf   = ovf_q;
    assign bus.irq   = irq_q;

endmodule

// File: tb/tb_uvma_tcounter_b_timer.sv
// Bench for uvma_tcounter_b_timer: directed scenarios plus random register
// traffic, every cycle compared against a rule-level model of the timer.
module tb_uvma_tcounter_b_timer;

    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int PMASK   = (1 << PRESC_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uvma_tcounter_b_if bus_if ();

    uvma_tcounter_b_timer #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int evt_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=0x%08h exp=0x%08h t=%0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_en, m_os, m_presc, m_cmp, m_cnt, m_pcnt, m_irq, m_ovfs;
    int m_evt, m_ovf, m_rdata;

    function automatic int m_read(input int a);
        case (a)
            0:       return m_en | (m_os << 1) | (m_presc << 8);
            1:       return m_cmp;
            2:       return m_cnt;
            default: return m_irq | (m_ovfs << 1);
        endcase
    endfunction

    task automatic model_step(input bit r, input bit wr, input bit rd, input int a, input logic [31:0] d);
        bit tick;
        if (r) begin
            m_en = 0; m_os = 0; m_presc = 0; m_cmp = 0; m_cnt = 0; m_pcnt = 0;
            m_irq = 0; m_ovfs = 0; m_evt = 0; m_ovf = 0; m_rdata = 0;
            return;
        end
        if (rd) begin
            m_rdata = m_read(a);
            exp_q.push_back(m_rdata);
        end
        m_evt = 0;
        m_ovf = 0;
        tick = (m_en != 0) && (m_pcnt == m_presc);
        if (m_en != 0) m_pcnt = tick ? 0 : ((m_pcnt + 1) & PMASK);
        if (tick) begin
            if (m_cnt == m_cmp) begin
                m_cnt = 0; m_evt = 1;
            end else if (m_cnt == MAXC) begin
                m_cnt = 0; m_ovf = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (wr && a == 2) begin
            m_cnt = int'(d) & MAXC; m_evt = 0; m_ovf = 0;
        end
        if (wr && a == 0 && d[2]) begin
            m_cnt = 0; m_pcnt = 0; m_evt = 0; m_ovf = 0;
        end
        if (wr && a == 3) begin
            if (d[0]) m_irq = 0;
            if (d[1]) m_ovfs = 0;
        end
        if (m_evt != 0) m_irq = 1;
        if (m_ovf != 0) m_ovfs = 1;
        if (m_evt != 0 && m_os != 0) m_en = 0;
        if (wr && a == 0) begin
            m_en = int'(d[0]); m_os = int'(d[1]); m_presc = int'(d >> 8) & PMASK;
        end
        if (wr && a == 1) m_cmp = int'(d) & MAXC;
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input bit r, input bit wr, input bit rd, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        reset         = r;
        bus_if.wr_en  = wr;
        bus_if.rd_en  = rd;
        bus_if.addr   = a;
        bus_if.wdata  = d;
        model_step(r, wr, rd, int'(a), d);
        @(posedge clk);
        #1;
        check_eq("evt", 32'(bus_if.evt), m_evt);
        check_eq("ovf", 32'(bus_if.ovf), m_ovf);
        check_eq("irq", 32'(bus_if.irq), m_irq);
        if (bus_if.evt) evt_seen++;
        if (rd && !r) begin
            check_eq("rd_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) check_eq("rdata", bus_if.rdata, exp_q.pop_front());
            last_rd = bus_if.rdata;
        end else begin
            check_eq("rdata_hold", bus_if.rdata, m_rdata);
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        bus_if.addr  = 2'd0;
        bus_if.wdata = 32'h0;

        // Reset, then every register reads 0.
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a));
            check_eq("rst_read", last_rd, 32'h0);
        end

        // Continuous compare: CMP=5, presc=0 -> evt every 6 cycles.
        wr_reg(2'd1, 32'd5);
        wr_reg(2'd0, 32'h1);
        evt_seen = 0;
        idle(36);
        check_eq("cont_evt_count", evt_seen, 6);
        check_eq("cont_irq_held", 32'(bus_if.irq), 32'h1);
        wr_reg(2'd3, 32'h1);
        check_eq("cont_irq_w1c", 32'(bus_if.irq), 32'h0);
        wr_reg(2'd0, 32'h4);

        // One-shot: CMP=3, presc=2 -> one evt, en auto-cleared, cnt at 0.
        wr_reg(2'd1, 32'd3);
        wr_reg(2'd0, 32'h0203);
        evt_seen = 0;
        idle(20);
        check_eq("oneshot_evts", evt_seen, 1);
        rd_reg(2'd0);
        check_eq("oneshot_ctrl", last_rd, 32'h0202);
        rd_reg(2'd2);
        check_eq("oneshot_cnt", last_rd, 32'h0);

        // Wrap: CNT=0xFE, CMP=0x10 -> ovf after 2 ticks.
        wr_reg(2'd0, 32'h4);
        wr_reg(2'd3, 32'h3);
        wr_reg(2'd1, 32'h10);
        wr_reg(2'd2, 32'hFE);
        wr_reg(2'd0, 32'h1);
        idle(2);
        check_eq("ovf_pulse", 32'(bus_if.ovf), 32'h1);
        rd_reg(2'd2);
        check_eq("ovf_cnt", last_rd, 32'h0);
        rd_reg(2'd3);
        check_eq("ovf_status", last_rd, 32'h2);
        wr_reg(2'd0, 32'h4);

        // CNT write on a matching tick beats the compare event.
        wr_reg(2'd3, 32'h3);
        wr_reg(2'd1, 32'd3);
        wr_reg(2'd0, 32'h1);
        idle(3);
        wr_reg(2'd2, 32'h40);
        check_eq("coll_evt", 32'(bus_if.evt), 32'h0);
        rd_reg(2'd2);
        check_eq("coll_cnt", last_rd, 32'h40);

        // W1C on the same cycle as an evt: irq stays set.
        wr_reg(2'd0, 32'h4);
        wr_reg(2'd0, 32'h1);
        idle(3);
        wr_reg(2'd3, 32'h1);
        check_eq("w1c_evt", 32'(bus_if.evt), 32'h1);
        check_eq("w1c_irq", 32'(bus_if.irq), 32'h1);

        // Reset while counting: everything clears and stays stopped.
        idle(5);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        check_eq("rst_irq", 32'(bus_if.irq), 32'h0);
        evt_seen = 0;
        idle(10);
        rd_reg(2'd2);
        check_eq("rst_cnt_hold", last_rd, 32'h0);
        rd_reg(2'd0);
        check_eq("rst_ctrl", last_rd, 32'h0);
        check_eq("rst_no_evt", evt_seen, 0);

        // Random register traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit r, wr, rd;
            logic [1:0]  a;
            logic [31:0] d;
            r  = ($urandom_range(0, 149) == 0);
            wr = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) == 0);
            a  = 2'($urandom_range(0, 3));
            case (a)
                2'd0: d = ($urandom & 32'hFFFF_00F8)
                        | (32'($urandom_range(0, 3)) << 8)
                        | (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0)
                        | (32'($urandom_range(0, 1)) << 1)
                        | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                2'd1: d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
                default: d = $urandom;
            endcase
            cyc(r, wr, rd, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uvma_tcounter_b_timer.md
# uvma_tcounter_b_timer

- Synthesizable timer/counter block: the responder end of the tcounter_b block-agent interface.
- The agent drives register writes and reads; this block counts prescaled clock ticks, compares against a programmed value and raises event and interrupt outputs.
- Used as the DUT-side model in the tcounter_b block environment and as the target of that interface's assertions.

## Interface
Parameters:
- CNT_W, 32, counter/compare width (8..32)
- PRESC_W, 8, prescaler field width

Ports:
- clk  in  1  block clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  register write strobe, one write per asserted cycle
- rd_en  in  1  register read strobe
- addr  in  2  register index, shared by read and write
- wdata  in  32  write data
- rdata  out  32  read data, valid the cycle after rd_en; holds its value otherwise
- evt  out  1  one-cycle pulse on compare match
- ovf  out  1  one-cycle pulse on counter wrap-around
- irq  out  1  level, equals STATUS.irq

## Operation
Registers; unimplemented bits read 0:
- 0 CTRL: [0] en, [1] one_shot, [2] clr (write-only, self-clearing, reads 0), [8+:PRESC_W] presc
- 1 CMP: [CNT_W-1:0] compare value
- 2 CNT: [CNT_W-1:0] counter; a write loads it
- 3 STATUS: [0] irq, [1] ovf_seen; write-1-to-clear

Prescaler:
- pcnt counts 0..presc while en=1.
- tick is asserted when en=1 and pcnt==presc; pcnt then returns to 0.
- presc=0 gives a tick every cycle.

Counter, on each tick:
- cnt==CMP: cnt←0, evt pulse, STATUS.irq←1; if one_shot=1, CTRL.en←0.
- else cnt==2^CNT_W−1: cnt←0, ovf pulse, STATUS.ovf_seen←1.
- else cnt←cnt+1.

Pause and clear:
- en=0: pcnt and cnt hold.
- CTRL write with clr=1: cnt←0 and pcnt←0 in the same update; the other CTRL fields are written normally.

Simultaneous events:
- Tick and counter update are evaluated on pre-write register values. A write takes effect on the next cycle's evaluation.
- CNT write or clr in the same cycle as a tick: the write/clear value wins; no evt/ovf for that tick.
- STATUS W1C in the same cycle as a hardware set: the set wins, bit stays 1.
- Write to CTRL.en=1 in the same cycle as a one-shot auto-clear: the write wins.
- rd_en and wr_en to the same address in one cycle: rdata returns the pre-write value.
- Writes to CNT/CMP truncate to CNT_W bits.

## Timing
- Reset values: rdata=0, evt=0, ovf=0, irq=0, all registers 0, pcnt=0.
- Reset asserted mid-count: everything returns to reset values on the next edge; no pulse is emitted in that cycle.
- Write latency: a register reflects wdata on the edge after the wr_en cycle.
- Read latency: 1 cycle.
- Count start: with presc=P, en set at edge N gives the first tick at edge N+P+1.
- evt, ovf and irq are registered and assert on the same edge that cnt is zeroed.
- irq stays high until W1C; no re-arm delay.

## Structure
- Shared package uvma_tcounter_b_pkg holds:
  - register address localparams (CTRL/CMP/CNT/STATUS)
  - CTRL bit-position constants
  - packed typedef of the CTRL register
- One natural sub-module: uvma_tcounter_b_presc (prescaler counter, tick output, clear input).
- Everything else stays in the top module: register file, counter, status, read mux.

## Test plan
- Reset, then read all 4 registers: all read 0; evt, ovf and irq are 0.
- CMP=5, presc=0, en=1, continuous: evt pulses every 6 cycles; irq sets on the first evt and stays high until STATUS write 0x1 clears it.
- CMP=3, presc=2, one_shot=1: single evt after 12 ticks of clk (4 counts × 3); en reads 0 afterwards; cnt holds 0.
- CNT_W=8, CNT=0xFE, CMP=0x10, presc=0: ovf pulses after 2 cycles; cnt=0; STATUS reads 0x2.
- Write CNT=0x40 in a tick cycle where cnt==CMP: no evt; cnt reads 0x40. STATUS W1C coincident with an evt: irq remains 1.
- Running counter, reset pulsed for 1 cycle: all outputs 0 next cycle; counting does not resume until en is rewritten.
